// File: rtl/alu_exec_unit_pkg.sv
// Shared types for the integer execute stage: instruction type codes and
// the per-instruction result bundle produced by the compute block.
package alu_exec_unit_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int ROB_WIDTH      = 4;
    localparam int INS_TYPE_WIDTH = 6;

    typedef enum logic [INS_TYPE_WIDTH-1:0] {
        INS_NOP   = 6'd0,
        INS_LUI   = 6'd1,
        INS_AUIPC = 6'd2,
        INS_JAL   = 6'd3,
        INS_JALR  = 6'd4,
        INS_BEQ   = 6'd5,
        INS_BNE   = 6'd6,
        INS_BLT   = 6'd7,
        INS_BGE   = 6'd8,
        INS_BLTU  = 6'd9,
        INS_BGEU  = 6'd10,
        INS_ADDI  = 6'd11,
        INS_SLTI  = 6'd12,
        INS_SLTIU = 6'd13,
        INS_XORI  = 6'd14,
        INS_ORI   = 6'd15,
        INS_ANDI  = 6'd16,
        INS_SLLI  = 6'd17,
        INS_SRLI  = 6'd18,
        INS_SRAI  = 6'd19,
        INS_ADD   = 6'd20,
        INS_SUB   = 6'd21,
        INS_SLL   = 6'd22,
        INS_SLT   = 6'd23,
        INS_SLTU  = 6'd24,
        INS_XOR   = 6'd25,
        INS_SRL   = 6'd26,
        INS_SRA   = 6'd27,
        INS_OR    = 6'd28,
        INS_AND   = 6'd29
    } ins_type_e;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] value;
        logic                  jump;
        logic [DATA_WIDTH-1:0] target;
    } alu_result_t;

    // I-type ALU ops take the immediate as second operand.
    function automatic logic is_imm_op(input ins_type_e op);
        return (op >= INS_ADDI) && (op <= INS_SRAI);
    endfunction

endpackage

// File: rtl/alu_compute.sv
// Combinational RV32I result, branch outcome and next-pc for one issued entry.
module alu_compute
    import alu_exec_unit_pkg::*;
(
    input  logic [INS_TYPE_WIDTH-1:0] ins_type,
    input  logic [DATA_WIDTH-1:0]     rs1,
    input  logic [DATA_WIDTH-1:0]     rs2,
    input  logic [DATA_WIDTH-1:0]     imm,
    input  logic [DATA_WIDTH-1:0]     pc,
    output alu_result_t               result
);

    ins_type_e             op;
    logic [DATA_WIDTH-1:0] op_b;
    logic [4:0]            shamt;
    logic [DATA_WIDTH-1:0] pc_plus4;
    logic [DATA_WIDTH-1:0] pc_imm;
    logic [DATA_WIDTH-1:0] jalr_sum;
    logic                  taken;

    always_comb begin
        op       = ins_type_e'(ins_type);
        op_b     = is_imm_op(op) ? imm : rs2;
        shamt    = op_b[4:0];
        pc_plus4 = pc + 32'd4;
        pc_imm   = pc + imm;
        jalr_sum = rs1 + imm;
        taken    = 1'b0;

        result.value  = '0;
        result.jump   = 1'b0;
        result.target = pc_plus4;

        case (op)
            INS_ADD, INS_ADDI:   result.value = rs1 + op_b;
            INS_SUB:             result.value = rs1 - rs2;
            INS_SLL, INS_SLLI:   result.value = rs1 << shamt;
            INS_SLT, INS_SLTI:   result.value = {31'd0, $signed(rs1) < $signed(op_b)};
            INS_SLTU, INS_SLTIU: result.value = {31'd0, rs1 < op_b};
            INS_XOR, INS_XORI:   result.value = rs1 ^ op_b;
            INS_SRL, INS_SRLI:   result.value = rs1 >> shamt;
            INS_SRA, INS_SRAI:   result.value = $unsigned($signed(rs1) >>> shamt);
            INS_OR, INS_ORI:     result.value = rs1 | op_b;
            INS_AND, INS_ANDI:   result.value = rs1 & op_b;
            INS_LUI:             result.value = imm;
            INS_AUIPC:           result.value = pc_imm;
            INS_JAL: begin
                result.value  = pc_plus4;
                result.jump   = 1'b1;
                result.target = pc_imm;
            end
            INS_JALR: begin
                result.value  = pc_plus4;
                result.jump   = 1'b1;
                result.target = {jalr_sum[DATA_WIDTH-1:1], 1'b0};
            end
            INS_BEQ, INS_BNE, INS_BLT, INS_BGE, INS_BLTU, INS_BGEU: begin
                case (op)
                    INS_BEQ:  taken = (rs1 == rs2);
                    INS_BNE:  taken = (rs1 != rs2);
                    INS_BLT:  taken = ($signed(rs1) < $signed(rs2));
                    INS_BGE:  taken = ($signed(rs1) >= $signed(rs2));
                    INS_BLTU: taken = (rs1 < rs2);
                    default:  taken = (rs1 >= rs2);
                endcase
                result.jump   = taken;
                result.target = taken ? pc_imm : pc_plus4;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Integer execute stage: computes issued RS entries and holds results in an
// in-order queue until the CDB arbiter grants the head entry.
module alu_exec_unit
    import alu_exec_unit_pkg::*;
#(
    parameter int QDEPTH = 4,
    parameter int ROB_W  = 4,
    parameter int TYPE_W = 6
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              clear_in,
    input  logic              rs2alu_enable,
    input  logic [31:0]       rs2alu_rs1,
    input  logic [31:0]       rs2alu_rs2,
    input  logic [31:0]       rs2alu_imm,
    input  logic [TYPE_W-1:0] rs2alu_ins_type,
    input  logic [31:0]       rs2alu_pc,
    input  logic [ROB_W-1:0]  rs2alu_reorder,
    output logic              alu_full,
    input  logic              cdb_grant,
    output logic              alu2cdb_valid,
    output logic [ROB_W-1:0]  alu2rs_bypass_reorder,
    output logic [31:0]       alu2rs_bypass_value,
    output logic              alu2rob_jump,
    output logic [31:0]       alu2rob_target,
    output logic              alu_overflow_err
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QDEPTH);
    localparam logic [CNT_W-1:0] FULL_C  = CNT_W'(QDEPTH - 1);

    logic [31:0]      value_q  [QDEPTH];
    logic [ROB_W-1:0] tag_q    [QDEPTH];
    logic             jump_q   [QDEPTH];
    logic [31:0]      target_q [QDEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic             full_q;
    logic             err_q;
    logic             pop;
    logic             push;
    logic             drop;
    alu_result_t      res;

    alu_compute u_compute (
        .ins_type (rs2alu_ins_type),
        .rs1      (rs2alu_rs1),
        .rs2      (rs2alu_rs2),
        .imm      (rs2alu_imm),
        .pc       (rs2alu_pc),
        .result   (res)
    );

    // A pop in the same cycle frees the slot, so a full queue still accepts the issue.
    always_comb begin
        pop       = rdy_in && !clear_in && (count != '0) && cdb_grant;
        push      = rdy_in && !clear_in && rs2alu_enable && ((count < DEPTH_C) || pop);
        drop      = rdy_in && !clear_in && rs2alu_enable && (count == DEPTH_C) && !pop;
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + CNT_W'(1);
        else if (pop && !push)
            count_nxt = count - CNT_W'(1);
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            full_q <= 1'b0;
            err_q  <= 1'b0;
            for (int unsigned i = 0; i < QDEPTH; i++) begin
                value_q[i]  <= '0;
                tag_q[i]    <= '0;
                jump_q[i]   <= 1'b0;
                target_q[i] <= '0;
            end
        end else if (rdy_in) begin
            if (clear_in) begin
                head   <= '0;
                tail   <= '0;
                count  <= '0;
                full_q <= 1'b0;
            end else begin
                if (push) begin
                    value_q[tail]  <= res.value;
                    tag_q[tail]    <= rs2alu_reorder;
                    jump_q[tail]   <= res.jump;
                    target_q[tail] <= res.target;
                    tail           <= tail + PTR_W'(1);
                end
                if (pop)
                    head <= head + PTR_W'(1);
                count  <= count_nxt;
                full_q <= (count_nxt >= FULL_C);
                if (drop)
                    err_q <= 1'b1;
            end
        end
    end

    assign alu_full              = full_q;
    assign alu_overflow_err      = err_q;
    assign alu2cdb_valid         = (count != '0);
    assign alu2rs_bypass_reorder = tag_q[head];
    assign alu2rs_bypass_value   = value_q[head];
    assign alu2rob_jump          = jump_q[head];
    assign alu2rob_target        = target_q[head];

endmodule
